// File: rtl/kp_gaussian_mac.sv
// 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1]/16, round-half-up) as a 3-stage pipeline
// that tags each output pixel with end-of-line / end-of-frame markers.
module kp_gaussian_mac #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned LINE_COUNT  = 480,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [3*DATA_WIDTH-1:0]   i_r0_data,
  input  logic [3*DATA_WIDTH-1:0]   i_r1_data,
  input  logic [3*DATA_WIDTH-1:0]   i_r2_data,
  input  logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_valid,
  output logic                      o_eol,
  output logic                      o_eof
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned SW   = DW + 2;
  localparam int unsigned TW   = DW + 4;
  localparam int unsigned ColW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned RowW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

  function automatic logic [SW-1:0] row_sum(input logic [3*DW-1:0] win);
    logic [SW-1:0] l, c, r;
    l = SW'(win[2*DW+:DW]);
    c = SW'(win[DW+:DW]);
    r = SW'(win[0+:DW]);
    return l + (c << 1) + r;
  endfunction

  // Position counters
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            eol_in, eof_in;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    eol_in = (col_q == ColW'(LINE_LENGTH - 1));
    eof_in = eol_in && (row_q == RowW'(LINE_COUNT - 1));
    if (i_valid) begin
      if (eol_in) begin
        col_d = '0;
        row_d = eof_in ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Stage 1: per-row horizontal sums
  logic [SW-1:0] s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
  logic          v1_q, eol1_q, eof1_q;

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (i_valid) begin
      s0_d = row_sum(i_r0_data);
      s1_d = row_sum(i_r1_data);
      s2_d = row_sum(i_r2_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      v1_q   <= 1'b0;
      eol1_q <= 1'b0;
      eof1_q <= 1'b0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      v1_q   <= i_valid;
      eol1_q <= i_valid & eol_in;
      eof1_q <= i_valid & eof_in;
    end
  end

  // Stage 2: vertical weighted sum
  logic [TW-1:0] t_q, t_d;
  logic          v2_q, eol2_q, eof2_q;

  always_comb begin
    t_d = t_q;
    if (v1_q) begin
      t_d = TW'(s0_q) + (TW'(s1_q) << 1) + TW'(s2_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      t_q    <= '0;
      v2_q   <= 1'b0;
      eol2_q <= 1'b0;
      eof2_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      v2_q   <= v1_q;
      eol2_q <= v1_q & eol1_q;
      eof2_q <= v1_q & eof1_q;
    end
  end

  // Stage 3: round-half-up divide by 16; max (16*(2^DW-1)+8) still fits in TW bits
  logic [TW-1:0]   rnd;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, eol_q, eof_q;

  always_comb begin
    rnd    = t_q + TW'(8);
    data_d = data_q;
    if (v2_q) begin
      data_d = rnd[TW-1:4];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= v2_q;
      eol_q   <= v2_q & eol2_q;
      eof_q   <= v2_q & eof2_q;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_eol   = eol_q;
  assign o_eof   = eof_q;

endmodule

// File: tb/tb_kp_gaussian_mac.sv
// Randomized + directed bench for kp_gaussian_mac against a per-cycle expectation table
// built from the kernel definition and the pixel index since reset.
module tb_kp_gaussian_mac;
  localparam int LL = 4;
  localparam int LC = 3;
  localparam int DW = 8;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [3*DW-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic          valid = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_eol, o_eof;

  kp_gaussian_mac #(
    .LINE_LENGTH(LL),
    .LINE_COUNT (LC),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_r0_data(r0),
    .i_r1_data(r1),
    .i_r2_data(r2),
    .i_valid  (valid),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_eol    (o_eol),
    .o_eof    (o_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int idx = 0;
  int eol_cnt = 0;
  int eof_cnt = 0;
  bit       exp_v  [N];
  bit [7:0] exp_d  [N];
  bit       exp_eol[N];
  bit       exp_eof[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int blur(input logic [3*DW-1:0] a, input logic [3*DW-1:0] b,
                              input logic [3*DW-1:0] c);
    logic [3*DW-1:0] rows[3];
    int sum;
    rows[0] = a; rows[1] = b; rows[2] = c;
    sum = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        int wt, pix;
        wt  = (k == 1 ? 2 : 1) * (j == 1 ? 2 : 1);
        pix = int'(rows[k][(2 - j)*DW +: DW]);
        sum += wt * pix;
      end
    end
    return (sum + 8) / 16;
  endfunction

  // Called 1ns after a rising edge; leaves 1ns after the next one.
  task automatic step(input logic [3*DW-1:0] a, input logic [3*DW-1:0] b,
                      input logic [3*DW-1:0] c, input bit v);
    int slot, col, row;
    r0 = a; r1 = b; r2 = c; valid = v;
    slot = (cyc + 3) % N;
    exp_v[slot]   = v;
    exp_d[slot]   = '0;
    exp_eol[slot] = 1'b0;
    exp_eof[slot] = 1'b0;
    if (v && rstn) begin
      col = idx % LL;
      row = (idx / LL) % LC;
      exp_d[slot]   = 8'(blur(a, b, c));
      exp_eol[slot] = (col == LL - 1);
      exp_eof[slot] = (col == LL - 1) && (row == LC - 1);
      idx++;
    end else begin
      exp_v[slot] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
  endtask

  task automatic assert_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_v[(cyc + k) % N] = 1'b0;
    idx = 0;
  endtask

  task automatic do_reset();
    assert_reset();
    idle(2);
    rstn = 1'b1;
    idle(1);
  endtask

  function automatic logic [3*DW-1:0] win(input int l, input int c, input int r);
    return {8'(l), 8'(c), 8'(r)};
  endfunction

  task automatic lit_one(input logic [3*DW-1:0] a, input logic [3*DW-1:0] b,
                         input logic [3*DW-1:0] c, input int want, input string name);
    step(a, b, c, 1'b1);
    idle(2);
    check({name, "_v"}, 32'(o_valid), 1);
    check(name, 32'(o_data), 32'(want));
  endtask

  // Per-cycle compare against the expectation table
  always @(negedge clk) begin
    int s;
    s = cyc % N;
    check("o_valid", 32'(o_valid), 32'(exp_v[s]));
    if (exp_v[s]) begin
      check("o_data", 32'(o_data), 32'(exp_d[s]));
      check("o_eol", 32'(o_eol), 32'(exp_eol[s]));
      check("o_eof", 32'(o_eof), 32'(exp_eof[s]));
    end else begin
      check("o_eol_idle", 32'(o_eol), 0);
      check("o_eof_idle", 32'(o_eof), 0);
    end
    if (o_valid && o_eol) eol_cnt++;
    if (o_valid && o_eof) eof_cnt++;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(o_data), 0);
    check("rst_valid", 32'(o_valid), 0);
    rstn = 1'b1;
    idle(1);

    // Uniform field: first output exactly 3 cycles after first input
    for (int i = 0; i < 10; i++) begin
      if (i == 2) check("uni_not_early", 32'(o_valid), 0);
      if (i == 3) begin
        check("uni_first_v", 32'(o_valid), 1);
        check("uni_first_d", 32'(o_data), 100);
      end
      step(win(100, 100, 100), win(100, 100, 100), win(100, 100, 100), 1'b1);
    end
    idle(4);

    // Hand-computed kernel points
    lit_one(win(0, 0, 0), win(0, 255, 0), win(0, 0, 0), 64, "impulse");
    lit_one(win(255, 0, 0), win(0, 0, 0), win(0, 0, 0), 16, "corner");
    lit_one(win(0, 255, 0), win(0, 0, 0), win(0, 0, 0), 32, "edge");
    lit_one(win(255, 255, 255), win(255, 255, 255), win(255, 255, 255), 255, "full");
    lit_one(win(0, 0, 0), win(0, 0, 0), win(0, 0, 0), 0, "zero");
    lit_one(win(1, 2, 3), win(4, 5, 6), win(7, 8, 9), 5, "ramp");

    // Tagging over two frames
    do_reset();
    eol_cnt = 0;
    eof_cnt = 0;
    for (int i = 0; i < 24; i++)
      step(win(i, i + 1, i + 2), win(i * 3, i * 2, i), win(200 - i, i, 7), 1'b1);
    idle(4);
    check("tag_eol_cnt", 32'(eol_cnt), 6);
    check("tag_eof_cnt", 32'(eof_cnt), 2);

    // Bubbles
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++)
        step(win(10 * i, 20 + i, 5), win(i, 100, 3 * i), win(9, 8, 16 * i), pat[i]);
      idle(4);
    end

    // Async reset mid-frame: pixel 3 (end of line) is on the outputs at this point
    do_reset();
    for (int i = 0; i < 6; i++)
      step(win(i, 50, i), win(30, i, 30), win(i, i, i), 1'b1);
    check("pre_rst_eol", 32'(o_eol), 1);
    #1;
    assert_reset();
    #1;
    check("async_valid", 32'(o_valid), 0);
    check("async_eol", 32'(o_eol), 0);
    check("async_eof", 32'(o_eof), 0);
    @(posedge clk);
    #1;
    idle(1);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle(1);
    eol_cnt = 0;
    for (int i = 0; i < 4; i++)
      step(win(i, 9, 9), win(9, i, 9), win(9, 9, i), 1'b1);
    idle(4);
    check("post_rst_eol_cnt", 32'(eol_cnt), 1);

    // Randomized traffic with random bubbles
    for (int i = 0; i < 300; i++)
      step(24'($urandom), 24'($urandom), 24'($urandom), ($urandom_range(0, 3) != 0));
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
